// File: rtl/clock_cfg_sequencer.sv
// Sequences clock-source and divider changes for the clocking block.
// Each change runs as gate, drain, apply, settle/lock, ungate, with a 4-phase req/ack handshake.
//
// state    | meaning
// IDLE     | waiting for a synchronized request; config latched on acceptance
// DRAIN    | clocks gated, letting in-flight edges drain before the change
// APPLY    | one cycle: shadow config driven onto the clocking block
// SETTLE   | clocks still gated while the new source/dividers settle
// LOCKWAIT | PLL selected but not yet locked; times out to the external clock
// ACK      | clocks enabled, ack raised until the request drops
module clock_cfg_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int DRAIN_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_TIMEOUT  = 255,
  parameter int CNT_W         = 8
) (
  input  logic       pll_clk,
  input  logic       resetb,
  input  logic       cfg_req,
  input  logic       cfg_ext_sel_in,
  input  logic [2:0] cfg_sel_in,
  input  logic [2:0] cfg_sel2_in,
  input  logic       pll_lock,
  output logic       ext_clk_sel_out,
  output logic [2:0] sel_out,
  output logic [2:0] sel2_out,
  output logic       clk_gate_en,
  output logic       cfg_ack,
  output logic       busy,
  output logic       cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_APPLY, S_SETTLE, S_LOCKWAIT, S_ACK
  } state_t;

  localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = '0;

  logic [SYNC_STAGES-1:0] req_sync;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   req_s;
  logic                   lock_s;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ext_nxt, gate_nxt, ack_nxt, err_nxt;
  logic [2:0]       sel_nxt, sel2_nxt;
  logic             sh_ext, sh_ext_nxt;
  logic [2:0]       sh_sel, sh_sel_nxt;
  logic [2:0]       sh_sel2, sh_sel2_nxt;

  always_ff @(posedge pll_clk or negedge resetb) begin
    if (!resetb) begin
      req_sync  <= '0;
      lock_sync <= '0;
    end else begin
      req_sync  <= {req_sync[SYNC_STAGES-2:0], cfg_req};
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_lock};
    end
  end

  assign req_s  = req_sync[SYNC_STAGES-1];
  assign lock_s = lock_sync[SYNC_STAGES-1];
  assign busy   = (state != S_IDLE);

  always_ff @(posedge pll_clk or negedge resetb) begin
    if (!resetb) begin
      state           <= S_IDLE;
      cnt             <= '0;
      ext_clk_sel_out <= 1'b1;
      sel_out         <= '0;
      sel2_out        <= '0;
      clk_gate_en     <= 1'b1;
      cfg_ack         <= 1'b0;
      cfg_err         <= 1'b0;
      sh_ext          <= 1'b0;
      sh_sel          <= '0;
      sh_sel2         <= '0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      ext_clk_sel_out <= ext_nxt;
      sel_out         <= sel_nxt;
      sel2_out        <= sel2_nxt;
      clk_gate_en     <= gate_nxt;
      cfg_ack         <= ack_nxt;
      cfg_err         <= err_nxt;
      sh_ext          <= sh_ext_nxt;
      sh_sel          <= sh_sel_nxt;
      sh_sel2         <= sh_sel2_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ext_nxt     = ext_clk_sel_out;
    sel_nxt     = sel_out;
    sel2_nxt    = sel2_out;
    gate_nxt    = clk_gate_en;
    ack_nxt     = cfg_ack;
    err_nxt     = cfg_err;
    sh_ext_nxt  = sh_ext;
    sh_sel_nxt  = sh_sel;
    sh_sel2_nxt = sh_sel2;

    case (state)
      S_IDLE: begin
        if (req_s) begin
          sh_ext_nxt  = cfg_ext_sel_in;
          sh_sel_nxt  = cfg_sel_in;
          sh_sel2_nxt = cfg_sel2_in;
          err_nxt     = 1'b0;
          if ({cfg_ext_sel_in, cfg_sel_in, cfg_sel2_in} ==
              {ext_clk_sel_out, sel_out, sel2_out}) begin
            state_nxt = S_ACK;
          end else begin
            gate_nxt  = 1'b0;
            cnt_nxt   = DRAIN_LOAD;
            state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (cnt == CNT_ZERO) state_nxt = S_APPLY;
        else                 cnt_nxt   = cnt - CNT_ONE;
      end
      S_APPLY: begin
        ext_nxt   = sh_ext;
        sel_nxt   = sh_sel;
        sel2_nxt  = sh_sel2;
        cnt_nxt   = SETTLE_LOAD;
        state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt != CNT_ZERO) begin
          cnt_nxt = cnt - CNT_ONE;
        end else if (!ext_clk_sel_out && !lock_s) begin
          cnt_nxt   = LOCK_LOAD;
          state_nxt = S_LOCKWAIT;
        end else begin
          gate_nxt  = 1'b1;
          state_nxt = S_ACK;
        end
      end
      S_LOCKWAIT: begin
        // lock takes priority over a timeout landing in the same cycle
        if (lock_s) begin
          gate_nxt  = 1'b1;
          state_nxt = S_ACK;
        end else if (cnt == CNT_ZERO) begin
          ext_nxt   = 1'b1;
          err_nxt   = 1'b1;
          gate_nxt  = 1'b1;
          state_nxt = S_ACK;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      S_ACK: begin
        gate_nxt = 1'b1;
        // ack is raised for at least one cycle even if the request already dropped
        if (!cfg_ack) begin
          ack_nxt = 1'b1;
        end else if (!req_s) begin
          ack_nxt   = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_clock_cfg_sequencer.sv
// Self-checking bench for clock_cfg_sequencer: directed scenarios plus randomized requests
// compared against a cycle-count / applied-config reference model.
module tb_clock_cfg_sequencer;
  localparam int SYNC    = 2;
  localparam int DRAIN   = 4;
  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 255;

  logic       pll_clk = 1'b0;
  logic       resetb = 1'b0;
  logic       cfg_req = 1'b0;
  logic       cfg_ext_sel_in = 1'b1;
  logic [2:0] cfg_sel_in = '0;
  logic [2:0] cfg_sel2_in = '0;
  logic       pll_lock = 1'b0;
  logic       ext_clk_sel_out, clk_gate_en, cfg_ack, busy, cfg_err;
  logic [2:0] sel_out, sel2_out;

  int checks = 0;
  int errors = 0;

  logic       m_ext;
  logic [2:0] m_sel, m_sel2;
  logic       m_err;

  clock_cfg_sequencer dut (
    .pll_clk(pll_clk), .resetb(resetb), .cfg_req(cfg_req),
    .cfg_ext_sel_in(cfg_ext_sel_in), .cfg_sel_in(cfg_sel_in), .cfg_sel2_in(cfg_sel2_in),
    .pll_lock(pll_lock), .ext_clk_sel_out(ext_clk_sel_out), .sel_out(sel_out),
    .sel2_out(sel2_out), .clk_gate_en(clk_gate_en), .cfg_ack(cfg_ack),
    .busy(busy), .cfg_err(cfg_err)
  );

  always #5 pll_clk = ~pll_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_applied(input string tag);
    check({tag, "_ext"}, 32'(ext_clk_sel_out), 32'(m_ext));
    check({tag, "_sel"}, 32'(sel_out), 32'(m_sel));
    check({tag, "_sel2"}, 32'(sel2_out), 32'(m_sel2));
    check({tag, "_err"}, 32'(cfg_err), 32'(m_err));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_gate"}, 32'(clk_gate_en), 32'd1);
    check({tag, "_ack"}, 32'(cfg_ack), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check_applied(tag);
  endtask

  // lock_rise: cycle (after request) at which pll_lock is driven high, -1 for none.
  // drop_at: cycle at which cfg_req is dropped early and cfg_sel_in disturbed, -1 for none.
  task automatic run_req(input string tag, input logic ext, input logic [2:0] sel,
                         input logic [2:0] sel2, input logic lock,
                         input int lock_rise, input int drop_at);
    int cyc, low, first_busy, exp_low, exp_ack, idle_cyc;
    logic changed, timed_out;
    logic [6:0] scramble;

    changed   = ({ext, sel, sel2} != {m_ext, m_sel, m_sel2});
    timed_out = changed && !ext && !lock && (lock_rise < 0);
    if (!changed)
      exp_low = 0;
    else if (!ext && !lock && lock_rise >= 0)
      exp_low = lock_rise;   // gate falls SYNC+1 after req, rises SYNC+1 after lock input
    else
      exp_low = DRAIN + 1 + SETTLE + (timed_out ? TIMEOUT : 0);
    exp_ack = SYNC + 2 + exp_low;

    @(negedge pll_clk);
    pll_lock       = lock;
    cfg_ext_sel_in = ext;
    cfg_sel_in     = sel;
    cfg_sel2_in    = sel2;
    cfg_req        = 1'b1;

    cyc = 0; low = 0; first_busy = -1;
    while (!cfg_ack && cyc < 2000) begin
      @(negedge pll_clk);
      cyc++;
      if (!clk_gate_en) low++;
      if (busy && first_busy < 0) begin
        first_busy = cyc;
        scramble = 7'($urandom);
        {cfg_ext_sel_in, cfg_sel_in, cfg_sel2_in} = scramble;
      end
      if (cyc == lock_rise) pll_lock = 1'b1;
      if (cyc == drop_at) begin
        cfg_req    = 1'b0;
        cfg_sel_in = ~sel;
      end
    end

    if (changed) begin
      m_ext  = timed_out ? 1'b1 : ext;
      m_sel  = sel;
      m_sel2 = sel2;
    end
    m_err = timed_out;

    check({tag, "_ack_seen"}, 32'(cfg_ack), 32'd1);
    check({tag, "_busy_lat"}, 32'(first_busy), 32'(SYNC + 1));
    check({tag, "_ack_lat"}, 32'(cyc), 32'(exp_ack));
    check({tag, "_gate_low"}, 32'(low), 32'(exp_low));
    check({tag, "_gate_ack"}, 32'(clk_gate_en), 32'd1);
    check_applied(tag);

    if (drop_at > 0) begin
      @(negedge pll_clk);
      check({tag, "_ack_pulse"}, 32'(cfg_ack), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
    end else begin
      cfg_req  = 1'b0;
      idle_cyc = 0;
      while (busy && idle_cyc < 20) begin
        @(negedge pll_clk);
        idle_cyc++;
      end
      check({tag, "_rel_lat"}, 32'(idle_cyc), 32'(SYNC + 1));
      check({tag, "_rel_ack"}, 32'(cfg_ack), 32'd0);
    end
    check({tag, "_err_hold"}, 32'(cfg_err), 32'(m_err));
  endtask

  task automatic model_reset();
    m_ext  = 1'b1;
    m_sel  = '0;
    m_sel2 = '0;
    m_err  = 1'b0;
  endtask

  initial begin
    logic       r_ext, r_lock;
    logic [2:0] r_sel, r_sel2;

    model_reset();
    repeat (3) @(negedge pll_clk);
    check_reset_vals("rst");
    resetb = 1'b1;
    repeat (2) @(negedge pll_clk);
    check_reset_vals("post_rst");

    run_req("nochg", 1'b1, 3'd0, 3'd0, 1'b0, -1, -1);
    run_req("pll_lock", 1'b0, 3'd3, 3'd5, 1'b1, -1, -1);
    run_req("timeout", 1'b0, 3'd2, 3'd1, 1'b0, -1, -1);
    run_req("late_lock", 1'b0, 3'd4, 3'd4, 1'b0, SYNC + 1 + DRAIN + 1 + SETTLE + 40, -1);

    // reset while in SETTLE with a new divider already applied
    @(negedge pll_clk);
    pll_lock = 1'b1; cfg_ext_sel_in = 1'b1; cfg_sel_in = 3'd6; cfg_sel2_in = 3'd7; cfg_req = 1'b1;
    repeat (SYNC + 1 + DRAIN + 1 + 5) @(negedge pll_clk);
    check("mid_sel_applied", 32'(sel_out), 32'd6);
    check("mid_gated", 32'(clk_gate_en), 32'd0);
    resetb = 1'b0;
    #1;
    model_reset();
    check_reset_vals("mid_rst");
    cfg_req = 1'b0;
    @(negedge pll_clk);
    resetb = 1'b1;
    repeat (3) @(negedge pll_clk);

    run_req("drop", 1'b1, 3'd5, 3'd2, 1'b1, -1, SYNC + 2);

    for (int i = 0; i < 12; i++) begin
      r_ext  = 1'($urandom);
      r_sel  = 3'($urandom);
      r_sel2 = 3'($urandom);
      r_lock = ($urandom_range(3, 0) != 0);
      if ($urandom_range(3, 0) == 0) begin
        r_ext = m_ext; r_sel = m_sel; r_sel2 = m_sel2;
      end
      run_req("rand", r_ext, r_sel, r_sel2, r_lock, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
